prbs_seq_ctrl: RTL and testbench

Run controller for the PRBS LFSR core. It sits between the register interface and the core. It accepts a PRBS configuration through a valid/ready handshake, flushes and reseeds the core, and gates the bit-rate tick into the core's LFSR shift enable. It stops the core after a programmed number of bits or full sequences, or on command, and reports progress counters plus a done pulse.

---
 rtl/prbs_seq_ctrl_if.sv | 23 ++
 rtl/prbs_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_prbs_seq_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prbs_seq_ctrl_if.sv
// Configuration channel into the PRBS run controller.
// A config transfers on the cycle where cfg_valid and cfg_ready are both high;
// the master holds pn/mode/count stable while cfg_valid is high, and cfg_ready
// does not depend on cfg_valid.
interface prbs_seq_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [4:0]       cfg_pn_select;
    logic [1:0]       cfg_mode;
    logic [CNT_W-1:0] cfg_count;

    modport master (
        output cfg_valid, cfg_pn_select, cfg_mode, cfg_count,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_pn_select, cfg_mode, cfg_count,
        output cfg_ready
    );
endinterface

// File: rtl/prbs_seq_ctrl.sv
// Run controller for the PRBS LFSR core: latches a config, flushes the core,
// gates bit ticks into the LFSR shift enable and stops on count or command.
module prbs_seq_ctrl #(
    parameter int FLUSH_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic             dac_clk,
    input  logic             reset,
    prbs_seq_ctrl_if.slave   cfg,
    input  logic             start,
    input  logic             stop,
    input  logic             bit_tick,
    input  logic             core_data_valid,
    output logic             core_reset_n,
    output logic [4:0]       core_pn_select,
    output logic             core_lfsr_clk_enable,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [CNT_W-1:0] bits_sent,
    output logic [CNT_W-1:0] seq_count,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_RUN    = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

    state_e           state_q;
    logic [FW-1:0]    flush_cnt_q;
    logic             core_reset_n_q;
    logic [4:0]       pn_q;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] count_q;
    logic             cfg_loaded_q;
    logic             cfg_err_q;
    logic             en_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] bits_q;
    logic [CNT_W-1:0] seq_q;

    logic             cfg_take;
    logic             cfg_legal;
    logic [CNT_W-1:0] bits_d;
    logic [CNT_W-1:0] seq_d;
    logic             seq_hit;
    logic             fwd_tick;
    logic             bit_hit;

    assign cfg_take  = cfg.cfg_valid && (state_q == ST_IDLE);
    assign cfg_legal = (cfg.cfg_pn_select <= 5'd14) && (cfg.cfg_mode != 2'd3) &&
                       !((cfg.cfg_mode != 2'd0) && (cfg.cfg_count == '0));

    // Saturating increments; the counters stick at all-ones instead of wrapping.
    assign bits_d = (bits_q == '1) ? bits_q : bits_q + 1'b1;
    assign seq_d  = (seq_q  == '1) ? seq_q  : seq_q  + 1'b1;

    // The terminating data_valid or a stop swallows a tick arriving in the same cycle.
    assign seq_hit  = core_data_valid && (mode_q == 2'd2) && (seq_d == count_q);
    assign fwd_tick = bit_tick && !stop && !seq_hit;
    assign bit_hit  = fwd_tick && (mode_q == 2'd1) && (bits_d == count_q);

    always_ff @(posedge dac_clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            flush_cnt_q    <= '0;
            core_reset_n_q <= 1'b0;
            pn_q           <= '0;
            mode_q         <= '0;
            count_q        <= '0;
            cfg_loaded_q   <= 1'b0;
            cfg_err_q      <= 1'b0;
            en_q           <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            bits_q         <= '0;
            seq_q          <= '0;
        end else begin
            en_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    core_reset_n_q <= 1'b1;
                    if (cfg_take) begin
                        if (cfg_legal) begin
                            pn_q         <= cfg.cfg_pn_select;
                            mode_q       <= cfg.cfg_mode;
                            count_q      <= cfg.cfg_count;
                            cfg_err_q    <= 1'b0;
                            cfg_loaded_q <= 1'b1;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                    // A config accepted this same cycle already counts as loaded.
                    if (start && (cfg_loaded_q || (cfg_take && cfg_legal))) begin
                        state_q        <= ST_FLUSH;
                        busy_q         <= 1'b1;
                        core_reset_n_q <= 1'b0;
                        flush_cnt_q    <= '0;
                        bits_q         <= '0;
                        seq_q          <= '0;
                    end
                end
                ST_FLUSH: begin
                    if (stop) begin
                        state_q        <= ST_FINISH;
                        done_q         <= 1'b1;
                        core_reset_n_q <= 1'b1;
                    end else if (flush_cnt_q == FLUSH_LAST) begin
                        state_q        <= ST_RUN;
                        core_reset_n_q <= 1'b1;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + FW'(1);
                    end
                end
                ST_RUN: begin
                    if (core_data_valid) begin
                        seq_q <= seq_d;
                    end
                    if (fwd_tick) begin
                        en_q   <= 1'b1;
                        bits_q <= bits_d;
                    end
                    if (stop || seq_hit || bit_hit) begin
                        state_q <= ST_FINISH;
                        done_q  <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cfg.cfg_ready          = (state_q == ST_IDLE);
    assign core_reset_n           = core_reset_n_q;
    assign core_pn_select         = pn_q;
    assign core_lfsr_clk_enable   = en_q;
    assign busy                   = busy_q;
    assign done                   = done_q;
    assign cfg_err                = cfg_err_q;
    assign bits_sent              = bits_q;
    assign seq_count              = seq_q;
    assign dbg_state_o            = state_q;

endmodule

// File: tb/tb_prbs_seq_ctrl.sv
// Directed bench for prbs_seq_ctrl: one task per scenario, inline comparisons
// against hand-computed values, one summary line at the end.
module tb_prbs_seq_ctrl;

    localparam int CNT_W = 32;

    logic             dac_clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             bit_tick = 1'b0;
    logic             core_data_valid = 1'b0;
    logic             core_reset_n;
    logic [4:0]       core_pn_select;
    logic             core_lfsr_clk_enable;
    logic             busy;
    logic             done;
    logic             cfg_err;
    logic [CNT_W-1:0] bits_sent;
    logic [CNT_W-1:0] seq_count;
    logic [1:0]       dbg_state;

    int checks = 0;
    int failures = 0;

    prbs_seq_ctrl_if #(.CNT_W(CNT_W)) cfg_if ();

    prbs_seq_ctrl #(.FLUSH_CYCLES(4), .CNT_W(CNT_W)) dut (
        .dac_clk              (dac_clk),
        .reset                (reset),
        .cfg                  (cfg_if.slave),
        .start                (start),
        .stop                 (stop),
        .bit_tick             (bit_tick),
        .core_data_valid      (core_data_valid),
        .core_reset_n         (core_reset_n),
        .core_pn_select       (core_pn_select),
        .core_lfsr_clk_enable (core_lfsr_clk_enable),
        .busy                 (busy),
        .done                 (done),
        .cfg_err              (cfg_err),
        .bits_sent            (bits_sent),
        .seq_count            (seq_count),
        .dbg_state_o          (dbg_state)
    );

    always #5 dac_clk = ~dac_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge dac_clk);
        #1;
    endtask

    task automatic offer_cfg(input logic [4:0] pn, input logic [1:0] mode, input logic [CNT_W-1:0] cnt);
        cfg_if.cfg_pn_select = pn;
        cfg_if.cfg_mode      = mode;
        cfg_if.cfg_count     = cnt;
        cfg_if.cfg_valid     = 1'b1;
        cyc();
        cfg_if.cfg_valid     = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_run();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (dbg_state == 2'd2) begin
                got = 1'b1;
                break;
            end
            cyc();
        end
        checks++;
        if (!got) begin failures++; $display("FAIL wait_run: state=%0d never reached RUN(2)", dbg_state); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_pn_select = '0;
        cfg_if.cfg_mode = '0;
        cfg_if.cfg_count = '0;
        cyc();
        cyc();
        reset = 1'b0;
        checks++; if (core_reset_n !== 1'b0) begin failures++; $display("FAIL rst_core_reset_n got=%0d exp=0", core_reset_n); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0d exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%0d exp=0", done); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL rst_cfg_err got=%0d exp=0", cfg_err); end
        checks++; if (core_pn_select !== 5'd0) begin failures++; $display("FAIL rst_pn got=%0d exp=0", core_pn_select); end
        checks++; if (core_lfsr_clk_enable !== 1'b0) begin failures++; $display("FAIL rst_enable got=%0d exp=0", core_lfsr_clk_enable); end
        checks++; if (bits_sent !== '0 || seq_count !== '0) begin failures++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", bits_sent, seq_count); end
        checks++; if (cfg_if.cfg_ready !== 1'b1) begin failures++; $display("FAIL rst_cfg_ready got=%0d exp=1", cfg_if.cfg_ready); end
        cyc();
        checks++; if (core_reset_n !== 1'b1) begin failures++; $display("FAIL idle_core_reset_n got=%0d exp=1", core_reset_n); end
    endtask

    task automatic test_ignored_start();
        pulse_start();
        checks++; if (busy !== 1'b0 || dbg_state !== 2'd0) begin failures++; $display("FAIL ign_start got busy=%0d state=%0d exp 0/0", busy, dbg_state); end
        cyc();
        checks++; if (core_reset_n !== 1'b1) begin failures++; $display("FAIL ign_start_core_reset_n got=%0d exp=1", core_reset_n); end
    endtask

    task automatic test_mode1_burst();
        int n_low, n_en, bad;
        bit seen, done_with_en, t;
        offer_cfg(5'd0, 2'd1, 32'd10);
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL m1_cfg_err got=%0d exp=0", cfg_err); end
        pulse_start();
        checks++; if (busy !== 1'b1 || dbg_state !== 2'd1) begin failures++; $display("FAIL m1_flush_entry got busy=%0d state=%0d exp 1/1", busy, dbg_state); end
        n_low = 0;
        for (int i = 0; i < 20; i++) begin
            if (core_reset_n !== 1'b0) break;
            n_low++;
            cyc();
        end
        checks++; if (n_low != 4) begin failures++; $display("FAIL m1_flush_len got=%0d exp=4", n_low); end
        checks++; if (dbg_state !== 2'd2) begin failures++; $display("FAIL m1_run_state got=%0d exp=2", dbg_state); end
        n_en = 0; bad = 0; seen = 0; done_with_en = 0;
        for (int i = 0; i < 100; i++) begin
            t = (i % 3 == 0);
            bit_tick = t;
            cyc();
            if (core_lfsr_clk_enable !== t) bad++;
            if (core_lfsr_clk_enable === 1'b1) n_en++;
            if (done === 1'b1) begin
                seen = 1'b1;
                done_with_en = core_lfsr_clk_enable;
                break;
            end
        end
        bit_tick = 1'b0;
        checks++; if (!seen) begin failures++; $display("FAIL m1_done_seen got=0 exp=1"); end
        checks++; if (n_en != 10) begin failures++; $display("FAIL m1_enable_count got=%0d exp=10", n_en); end
        checks++; if (bad != 0) begin failures++; $display("FAIL m1_enable_timing got=%0d bad cycles exp=0", bad); end
        checks++; if (done_with_en !== 1'b1) begin failures++; $display("FAIL m1_done_with_last_enable got=%0d exp=1", done_with_en); end
        checks++; if (bits_sent !== 32'd10) begin failures++; $display("FAIL m1_bits_sent got=%0d exp=10", bits_sent); end
        cyc();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL m1_after_done got busy=%0d done=%0d exp 0/0", busy, done); end
        checks++; if (bits_sent !== 32'd10) begin failures++; $display("FAIL m1_bits_hold got=%0d exp=10", bits_sent); end
    endtask

    task automatic test_mode2_burst();
        int bad;
        offer_cfg(5'd0, 2'd2, 32'd3);
        pulse_start();
        wait_run();
        bad = 0;
        for (int i = 0; i < 21; i++) begin
            bit_tick = 1'b1;
            core_data_valid = (i % 7 == 6);
            cyc();
            if (i < 20) begin
                if (core_lfsr_clk_enable !== 1'b1 || done !== 1'b0) bad++;
            end
        end
        bit_tick = 1'b0;
        core_data_valid = 1'b0;
        checks++; if (bad != 0) begin failures++; $display("FAIL m2_run_cycles got=%0d bad cycles exp=0", bad); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL m2_done got=%0d exp=1", done); end
        checks++; if (core_lfsr_clk_enable !== 1'b0) begin failures++; $display("FAIL m2_no_enable_after_last_dv got=%0d exp=0", core_lfsr_clk_enable); end
        checks++; if (seq_count !== 32'd3) begin failures++; $display("FAIL m2_seq_count got=%0d exp=3", seq_count); end
        checks++; if (bits_sent !== 32'd20) begin failures++; $display("FAIL m2_bits_sent got=%0d exp=20", bits_sent); end
        cyc();
        checks++; if (busy !== 1'b0 || core_lfsr_clk_enable !== 1'b0) begin failures++; $display("FAIL m2_idle got busy=%0d en=%0d exp 0/0", busy, core_lfsr_clk_enable); end
    endtask

    task automatic test_illegal_cfg();
        offer_cfg(5'd3, 2'd0, 32'd0);
        checks++; if (cfg_err !== 1'b0 || core_pn_select !== 5'd3) begin failures++; $display("FAIL ill_base got err=%0d pn=%0d exp 0/3", cfg_err, core_pn_select); end
        offer_cfg(5'd15, 2'd0, 32'd5);
        checks++; if (cfg_err !== 1'b1 || core_pn_select !== 5'd3) begin failures++; $display("FAIL ill_pn15 got err=%0d pn=%0d exp 1/3", cfg_err, core_pn_select); end
        offer_cfg(5'd2, 2'd3, 32'd5);
        checks++; if (cfg_err !== 1'b1 || core_pn_select !== 5'd3) begin failures++; $display("FAIL ill_mode3 got err=%0d pn=%0d exp 1/3", cfg_err, core_pn_select); end
        offer_cfg(5'd2, 2'd1, 32'd0);
        checks++; if (cfg_err !== 1'b1 || core_pn_select !== 5'd3) begin failures++; $display("FAIL ill_count0 got err=%0d pn=%0d exp 1/3", cfg_err, core_pn_select); end
        offer_cfg(5'd14, 2'd1, 32'd5);
        checks++; if (cfg_err !== 1'b0 || core_pn_select !== 5'd14) begin failures++; $display("FAIL ill_recover got err=%0d pn=%0d exp 0/14", cfg_err, core_pn_select); end
    endtask

    task automatic test_stop_mode0();
        int n_en;
        offer_cfg(5'd2, 2'd0, 32'd0);
        pulse_start();
        wait_run();
        n_en = 0;
        for (int i = 0; i < 200; i++) begin
            bit_tick = (i % 2 == 0);
            cyc();
            if (core_lfsr_clk_enable === 1'b1) n_en++;
            if (n_en == 20) break;
        end
        checks++; if (n_en != 20) begin failures++; $display("FAIL stop_pre_enables got=%0d exp=20", n_en); end
        bit_tick = 1'b1;
        stop = 1'b1;
        cyc();
        bit_tick = 1'b0;
        stop = 1'b0;
        checks++; if (core_lfsr_clk_enable !== 1'b0) begin failures++; $display("FAIL stop_no_21st got=%0d exp=0", core_lfsr_clk_enable); end
        checks++; if (done !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL stop_done got done=%0d busy=%0d exp 1/1", done, busy); end
        checks++; if (bits_sent !== 32'd20) begin failures++; $display("FAIL stop_bits_sent got=%0d exp=20", bits_sent); end
        cyc();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL stop_busy_fall got busy=%0d done=%0d exp 0/0", busy, done); end
    endtask

    task automatic test_cfg_during_run();
        offer_cfg(5'd4, 2'd0, 32'd0);
        pulse_start();
        wait_run();
        checks++; if (cfg_if.cfg_ready !== 1'b0) begin failures++; $display("FAIL run_cfg_ready got=%0d exp=0", cfg_if.cfg_ready); end
        offer_cfg(5'd9, 2'd1, 32'd7);
        checks++; if (core_pn_select !== 5'd4 || cfg_err !== 1'b0) begin failures++; $display("FAIL run_cfg_ignored got pn=%0d err=%0d exp 4/0", core_pn_select, cfg_err); end
        bit_tick = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        bit_tick = 1'b0;
        cyc();
        checks++; if (busy !== 1'b1 || bits_sent !== 32'd10) begin failures++; $display("FAIL run_mode_kept got busy=%0d bits=%0d exp 1/10", busy, bits_sent); end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        cyc();
        checks++; if (busy !== 1'b0 || core_pn_select !== 5'd4) begin failures++; $display("FAIL run_end got busy=%0d pn=%0d exp 0/4", busy, core_pn_select); end
    endtask

    task automatic test_reset_mid();
        offer_cfg(5'd5, 2'd0, 32'd0);
        pulse_start();
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++; if (dbg_state !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rflush_state got state=%0d busy=%0d done=%0d exp 0/0/0", dbg_state, busy, done); end
        checks++; if (core_reset_n !== 1'b0 || core_pn_select !== 5'd0) begin failures++; $display("FAIL rflush_outputs got rstn=%0d pn=%0d exp 0/0", core_reset_n, core_pn_select); end
        cyc();
        checks++; if (core_reset_n !== 1'b1) begin failures++; $display("FAIL rflush_rstn_idle got=%0d exp=1", core_reset_n); end
        pulse_start();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rflush_start_ignored got busy=%0d exp=0", busy); end
        offer_cfg(5'd6, 2'd0, 32'd0);
        pulse_start();
        wait_run();
        bit_tick = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        bit_tick = 1'b0;
        checks++; if (bits_sent !== '0 || seq_count !== '0 || core_lfsr_clk_enable !== 1'b0) begin failures++; $display("FAIL rrun_counters got bits=%0d seq=%0d en=%0d exp 0/0/0", bits_sent, seq_count, core_lfsr_clk_enable); end
        checks++; if (busy !== 1'b0 || core_pn_select !== 5'd0 || cfg_if.cfg_ready !== 1'b1) begin failures++; $display("FAIL rrun_outputs got busy=%0d pn=%0d rdy=%0d exp 0/0/1", busy, core_pn_select, cfg_if.cfg_ready); end
        cyc();
        pulse_start();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rrun_start_ignored got busy=%0d exp=0", busy); end
    endtask

    task automatic test_cfg_with_start();
        int n_en;
        bit seen;
        cfg_if.cfg_pn_select = 5'd1;
        cfg_if.cfg_mode      = 2'd1;
        cfg_if.cfg_count     = 32'd2;
        cfg_if.cfg_valid     = 1'b1;
        start                = 1'b1;
        cyc();
        cfg_if.cfg_valid     = 1'b0;
        start                = 1'b0;
        checks++; if (busy !== 1'b1 || core_pn_select !== 5'd1) begin failures++; $display("FAIL cws_start got busy=%0d pn=%0d exp 1/1", busy, core_pn_select); end
        wait_run();
        n_en = 0; seen = 0;
        for (int i = 0; i < 10; i++) begin
            bit_tick = 1'b1;
            cyc();
            if (core_lfsr_clk_enable === 1'b1) n_en++;
            if (done === 1'b1) begin seen = 1'b1; break; end
        end
        bit_tick = 1'b0;
        checks++; if (!seen || n_en != 2) begin failures++; $display("FAIL cws_burst got done=%0d enables=%0d exp 1/2", seen, n_en); end
        cyc();
        pulse_start();
        cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        checks++; if (done !== 1'b1 || dbg_state !== 2'd3) begin failures++; $display("FAIL flush_stop got done=%0d state=%0d exp 1/3", done, dbg_state); end
        cyc();
        checks++; if (busy !== 1'b0 || core_reset_n !== 1'b1) begin failures++; $display("FAIL flush_stop_idle got busy=%0d rstn=%0d exp 0/1", busy, core_reset_n); end
    endtask

    initial begin
        test_reset();
        test_ignored_start();
        test_mode1_burst();
        test_mode2_burst();
        test_illegal_cfg();
        test_stop_mode0();
        test_cfg_during_run();
        test_reset_mid();
        test_cfg_with_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
